// File: rtl/bus_keeper_bank.sv
// Multi-source bus keeper: wired-AND resolution, contention flagging and a held bus value.
// Define BUS_KEEPER_DECAY_EN to build the idle counter that relaxes an undriven bus to DECAY_VAL.
module bus_keeper_bank #(
   parameter int              WIDTH        = 8,
   parameter int              NUM_SRC      = 2,
   parameter int              DECAY_CYCLES = 16,
   parameter logic [WIDTH-1:0] DECAY_VAL    = {WIDTH{1'b1}}
) (
   input  logic                     CLK,
   input  logic                     RESET,
   input  logic [NUM_SRC-1:0]       SRC_OE,
   input  logic [NUM_SRC*WIDTH-1:0] SRC_D,
   input  logic                     CONFLICT_CLR,
   output logic [WIDTH-1:0]         Q,
   output logic                     DRIVEN,
   output logic                     DECAYED,
   output logic                     CONFLICT,
   output logic                     CONFLICT_STICKY
);

   // Valid/ready does not apply here: every source drives when its SRC_OE bit is
   // high and receivers sample Q whenever they like; Q is valid at all times.

   typedef enum logic [1:0] {
      ST_HLD = 2'd0,
      ST_DRV = 2'd1,
      ST_DCY = 2'd2
   } state_t;

   logic [WIDTH-1:0] resolved;
   logic             any_oe;
   logic             multi_oe;

   logic [WIDTH-1:0] s_q, s_d;
   state_t           state_q, state_d;
   logic             sticky_q, sticky_d;

   // Only enabled sources enter the AND, so a floating SRC_D bit is never sampled.
   always_comb begin
      resolved = '1;
      any_oe   = 1'b0;
      multi_oe = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (SRC_OE[i]) begin
            multi_oe = multi_oe | any_oe;
            any_oe   = 1'b1;
            resolved = resolved & SRC_D[i*WIDTH +: WIDTH];
         end
      end
   end

   assign DRIVEN   = any_oe;
   assign CONFLICT = (NUM_SRC > 1) ? multi_oe : 1'b0;
   assign Q        = any_oe ? resolved : s_q;

`ifdef BUS_KEEPER_DECAY_EN
   localparam int              CNT_W    = $clog2(DECAY_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DECAY_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECAY_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      s_d     = s_q;
      state_d = state_q;
      cnt_d   = cnt_q;
      if (any_oe) begin
         s_d     = resolved;
         state_d = ST_DRV;
         cnt_d   = '0;
      end else if (cnt_q < CNT_MAX) begin
         cnt_d = cnt_q + CNT_W'(1);
         if (cnt_q == CNT_LAST) begin
            s_d     = DECAY_VAL;
            state_d = ST_DCY;
         end else begin
            state_d = ST_HLD;
         end
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign DECAYED = (state_q == ST_DCY);
`else
   always_comb begin
      s_d     = s_q;
      state_d = ST_HLD;
      if (any_oe) begin
         s_d     = resolved;
         state_d = ST_DRV;
      end
   end

   assign DECAYED = 1'b0;
`endif

   // Set dominates clear so a contention on the clearing edge is never lost.
   always_comb begin
      sticky_d = sticky_q;
      if (CONFLICT) begin
         sticky_d = 1'b1;
      end else if (CONFLICT_CLR) begin
         sticky_d = 1'b0;
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         s_q      <= '0;
         state_q  <= ST_HLD;
         sticky_q <= 1'b0;
      end else begin
         s_q      <= s_d;
         state_q  <= state_d;
         sticky_q <= sticky_d;
      end
   end

   assign CONFLICT_STICKY = (NUM_SRC > 1) ? sticky_q : 1'b0;

endmodule

// File: tb/tb_bus_keeper_bank.sv
// Directed bench for bus_keeper_bank (default parameters); expectations follow
// BUS_KEEPER_DECAY_EN when it is defined for the build.
module tb_bus_keeper_bank;

   logic        clk;
   logic        rst;
   logic [1:0]  oe;
   logic [15:0] d;
   logic        clr;
   logic [7:0]  q;
   logic        driven;
   logic        decayed;
   logic        conflict;
   logic        sticky;

   int checks   = 0;
   int failures = 0;

   bus_keeper_bank dut (
      .CLK             (clk),
      .RESET           (rst),
      .SRC_OE          (oe),
      .SRC_D           (d),
      .CONFLICT_CLR    (clr),
      .Q               (q),
      .DRIVEN          (driven),
      .DECAYED         (decayed),
      .CONFLICT        (conflict),
      .CONFLICT_STICKY (sticky)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   typedef struct {
      logic [1:0]  oe;
      logic [15:0] d;
      logic [7:0]  q;
      logic        drv;
      logic        cf;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      rst = 1'b1;
      oe  = 2'b00;
      d   = 16'h0000;
      clr = 1'b0;

      // T1: reset values, then transparency while still in reset
      #2;
      check("t1_q_reset", 32'(q), 32'h00);
      check("t1_decayed_reset", 32'(decayed), 32'h0);
      check("t1_sticky_reset", 32'(sticky), 32'h0);
      check("t1_driven_reset", 32'(driven), 32'h0);
      oe = 2'b01;
      d  = 16'h005A;
      #1;
      check("t1_q_transparent", 32'(q), 32'h5A);
      check("t1_driven", 32'(driven), 32'h1);
      oe  = 2'b00;
      rst = 1'b0;

      // Combinational resolution table
      vecs[0] = '{oe: 2'b01, d: 16'h005A, q: 8'h5A, drv: 1'b1, cf: 1'b0};
      vecs[1] = '{oe: 2'b10, d: 16'hC3FF, q: 8'hC3, drv: 1'b1, cf: 1'b0};
      vecs[2] = '{oe: 2'b11, d: 16'h3CF0, q: 8'h30, drv: 1'b1, cf: 1'b1};
      vecs[3] = '{oe: 2'b11, d: 16'hFFFF, q: 8'hFF, drv: 1'b1, cf: 1'b1};
      vecs[4] = '{oe: 2'b11, d: 16'h00A5, q: 8'h00, drv: 1'b1, cf: 1'b1};
      vecs[5] = '{oe: 2'b10, d: 16'h8100, q: 8'h81, drv: 1'b1, cf: 1'b0};
      for (int i = 0; i < 6; i++) begin
         oe = vecs[i].oe;
         d  = vecs[i].d;
         @(negedge clk);
         check($sformatf("vec%0d_q", i), 32'(q), 32'(vecs[i].q));
         check($sformatf("vec%0d_driven", i), 32'(driven), 32'(vecs[i].drv));
         check($sformatf("vec%0d_conflict", i), 32'(conflict), 32'(vecs[i].cf));
      end
      oe  = 2'b00;
      clr = 1'b1;
      tick(1);
      clr = 1'b0;
      check("table_sticky_cleared", 32'(sticky), 32'h0);
      check("table_hold_last", 32'(q), 32'h81);

      // T2: hold through 15 idle edges
      oe = 2'b01;
      d  = 16'h003C;
      tick(1);
      oe = 2'b00;
      tick(15);
      check("t2_q_hold", 32'(q), 32'h3C);
      check("t2_decayed", 32'(decayed), 32'h0);
      check("t2_driven", 32'(driven), 32'h0);

      // T3: 16th idle edge
      tick(1);
`ifdef BUS_KEEPER_DECAY_EN
      check("t3_q_decay", 32'(q), 32'hFF);
      check("t3_decayed", 32'(decayed), 32'h1);
      tick(5);
      check("t3_q_saturated", 32'(q), 32'hFF);
      check("t3_decayed_held", 32'(decayed), 32'h1);
      oe = 2'b01;
      d  = 16'h0011;
      tick(1);
      check("t3_redrive_decayed", 32'(decayed), 32'h0);
      check("t3_redrive_q", 32'(q), 32'h11);
      oe = 2'b00;
      tick(1);
      check("t3_redrive_hold", 32'(q), 32'h11);
`else
      check("t3_q_no_decay", 32'(q), 32'h3C);
      check("t3_decayed_tied", 32'(decayed), 32'h0);
      tick(99);
      check("t3_q_100_edges", 32'(q), 32'h3C);
      check("t3_decayed_100_edges", 32'(decayed), 32'h0);
`endif

      // T4: a single driven edge restarts the idle window
      oe = 2'b00;
      tick(10);
      oe = 2'b01;
      d  = 16'h0081;
      tick(1);
      oe = 2'b00;
      tick(15);
      check("t4_q_hold", 32'(q), 32'h81);
      check("t4_decayed", 32'(decayed), 32'h0);
      tick(1);
`ifdef BUS_KEEPER_DECAY_EN
      check("t4_q_decay", 32'(q), 32'hFF);
      check("t4_decayed_after", 32'(decayed), 32'h1);
`else
      check("t4_q_no_decay", 32'(q), 32'h81);
      check("t4_decayed_after", 32'(decayed), 32'h0);
`endif

      // T5: contention, sticky set/clear priority
      oe = 2'b11;
      d  = 16'h3CF0;
      #1;
      check("t5_q_and", 32'(q), 32'h30);
      check("t5_conflict", 32'(conflict), 32'h1);
      check("t5_sticky_pre_edge", 32'(sticky), 32'h0);
      tick(1);
      check("t5_sticky_set", 32'(sticky), 32'h1);
      clr = 1'b1;
      tick(1);
      check("t5_sticky_set_wins", 32'(sticky), 32'h1);
      oe = 2'b01;
      tick(1);
      check("t5_sticky_cleared", 32'(sticky), 32'h0);
      check("t5_conflict_gone", 32'(conflict), 32'h0);
      clr = 1'b0;
      oe  = 2'b11;
      tick(1);
      oe = 2'b00;
      tick(3);
      check("t5_sticky_held", 32'(sticky), 32'h1);
      check("t5_q_after_conflict", 32'(q), 32'h30);

      // T6: asynchronous reset mid-window restarts the counter
      oe = 2'b01;
      d  = 16'h00A5;
      tick(1);
      oe = 2'b00;
      tick(8);
      check("t6_q_hold", 32'(q), 32'hA5);
      #2;
      rst = 1'b1;
      #1;
      check("t6_q_async_reset", 32'(q), 32'h00);
      check("t6_sticky_async_reset", 32'(sticky), 32'h0);
      check("t6_decayed_async_reset", 32'(decayed), 32'h0);
      rst = 1'b0;
      tick(15);
      check("t6_q_15_edges", 32'(q), 32'h00);
      check("t6_decayed_15_edges", 32'(decayed), 32'h0);
      tick(1);
`ifdef BUS_KEEPER_DECAY_EN
      check("t6_q_decay", 32'(q), 32'hFF);
      check("t6_decayed", 32'(decayed), 32'h1);
`else
      check("t6_q_no_decay", 32'(q), 32'h00);
      check("t6_decayed", 32'(decayed), 32'h0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
